ipv_expander: RTL and testbench

- Inverse of the IPV reduction path: takes a vote count (0..K) per group and re-expands it into a K-bit serial stream carrying exactly that many 1s.
- Groups are framed so a downstream K-bit popcount reducer reproduces the count.
- Sits between the count-producing logic and any serial IPV consumer.
- Has a small input FIFO with valid/ready handshakes on both sides.

---
 rtl/ipv_expander_if.sv | 24 ++
 rtl/ipv_expander.sv | 125 ++++++++++++
 tb/tb_ipv_expander.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ipv_expander_if.sv
// rtl/ipv_expander_if.sv - count-in / serial-bit-out handshake bundle for ipv_expander
interface ipv_expander_if #(
  parameter int CW = 4
);
  logic [CW-1:0] cnt_in;
  logic          cnt_valid;
  logic          cnt_ready;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready;
  logic          sof;
  logic          busy;
  logic          sat_err;

  modport master (
    output cnt_in, cnt_valid, bit_ready,
    input  cnt_ready, bit_out, bit_valid, sof, busy, sat_err
  );

  modport slave (
    input  cnt_in, cnt_valid, bit_ready,
    output cnt_ready, bit_out, bit_valid, sof, busy, sat_err
  );
endinterface

// File: rtl/ipv_expander.sv
// rtl/ipv_expander.sv - re-expands per-group vote counts into K-bit serial IPV groups
module ipv_expander #(
  parameter int K          = 4,
  parameter int CW         = 4,
  parameter int DEPTH      = 2,
  parameter int ONES_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ipv_expander_if.slave  io
);
  localparam int            AW   = $clog2(DEPTH);
  localparam int            W    = (CW > 3) ? CW : 3;
  localparam logic [CW-1:0] K_C  = CW'(K);
  localparam logic [2:0]    LAST = 3'(K - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [CW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_occ;
  logic          r_sat;
  state_t        r_state;
  logic [2:0]    r_pos;
  logic [CW-1:0] r_cur;

  state_t        w_state_nxt;
  logic [2:0]    w_pos_nxt;
  logic [CW-1:0] w_cur_nxt;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_over;
  logic [CW-1:0] w_wdata;
  logic          w_shift;
  logic          w_one;
  logic [W:0]    w_pos_x;
  logic [W:0]    w_cur_x;

  assign w_full  = (r_occ == FULL);
  assign w_empty = (r_occ == '0);
  assign w_push  = io.cnt_valid && !w_full;
  assign w_over  = (io.cnt_in > K_C);
  assign w_wdata = w_over ? K_C : io.cnt_in;
  assign w_shift = (r_state == S_SHIFT);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_occ   <= '0;
      r_sat   <= 1'b0;
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_cur   <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      r_sat   <= w_push && w_over;
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_cur   <= w_cur_nxt;
    end
  end

  // The last bit of a group reloads straight from the FIFO so back-to-back groups have no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_cur_nxt   = r_cur;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cur_nxt   = r_mem[r_rd];
          w_pos_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (io.bit_ready) begin
          if (r_pos != LAST) begin
            w_pos_nxt = r_pos + 1'b1;
          end else if (!w_empty) begin
            w_pop     = 1'b1;
            w_cur_nxt = r_mem[r_rd];
            w_pos_nxt = '0;
          end else begin
            w_pos_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // pos + cur >= K is the underflow-free form of pos >= K - cur.
  always_comb begin
    w_pos_x = (W + 1)'(r_pos);
    w_cur_x = (W + 1)'(r_cur);
    if (ONES_FIRST != 0) w_one = (w_pos_x < w_cur_x);
    else                 w_one = ((w_pos_x + w_cur_x) >= (W + 1)'(K));
  end

  assign io.cnt_ready = !w_full;
  assign io.bit_valid = w_shift;
  assign io.sof       = w_shift && (r_pos == '0);
  assign io.bit_out   = w_shift && w_one;
  assign io.busy      = !w_empty || w_shift;
  assign io.sat_err   = r_sat;
endmodule

// File: tb/tb_ipv_expander.sv
// tb/tb_ipv_expander.sv - scoreboard bench for ipv_expander in both bit orders with popcount round trip
module tb_ipv_expander;
  localparam int K = 4, CW = 4, DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [CW-1:0] cnt_in = '0;
  logic          cnt_valid = 1'b0;
  logic          bit_ready = 1'b1;

  ipv_expander_if #(.CW(CW)) if1 ();
  ipv_expander_if #(.CW(CW)) if0 ();

  assign if1.cnt_in = cnt_in;  assign if1.cnt_valid = cnt_valid;  assign if1.bit_ready = bit_ready;
  assign if0.cnt_in = cnt_in;  assign if0.cnt_valid = cnt_valid;  assign if0.bit_ready = bit_ready;

  ipv_expander #(.K(K), .CW(CW), .DEPTH(DEPTH), .ONES_FIRST(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io(if1));
  ipv_expander #(.K(K), .CW(CW), .DEPTH(DEPTH), .ONES_FIRST(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .io(if0));

  typedef struct { bit b; bit s; } exp_t;
  exp_t q1[$];
  exp_t q0[$];
  int   c1[$];
  int   c0[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   rnd_en = 1'b0;
  int   nb1 = 0, acc1 = 0, nb0 = 0, acc0 = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: a saturated count v becomes v ones then K-v zeros (or mirrored), sof on bit 0.
  task automatic model_push(input int c);
    int v;
    v = (c > K) ? K : c;
    for (int i = 0; i < K; i++) begin
      q1.push_back('{b: (i < v), s: (i == 0)});
      q0.push_back('{b: (i >= K - v), s: (i == 0)});
    end
    c1.push_back(v);
    c0.push_back(v);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q1.delete(); c1.delete(); nb1 = 0; acc1 = 0;
    end else if (if1.bit_valid && if1.bit_ready) begin
      if (q1.size() == 0) fail_now("ones_first unexpected bit");
      else begin
        e = q1.pop_front();
        check("ones_first bit_out", if1.bit_out, e.b);
        check("ones_first sof", if1.sof, e.s);
      end
      acc1 += int'(if1.bit_out);
      nb1++;
      if (nb1 == K) begin
        if (c1.size() == 0) fail_now("ones_first roundtrip no count");
        else check("ones_first roundtrip", acc1, c1.pop_front());
        nb1 = 0; acc1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q0.delete(); c0.delete(); nb0 = 0; acc0 = 0;
    end else if (if0.bit_valid && if0.bit_ready) begin
      if (q0.size() == 0) fail_now("ones_last unexpected bit");
      else begin
        e = q0.pop_front();
        check("ones_last bit_out", if0.bit_out, e.b);
        check("ones_last sof", if0.sof, e.s);
      end
      acc0 += int'(if0.bit_out);
      nb0++;
      if (nb0 == K) begin
        if (c0.size() == 0) fail_now("ones_last roundtrip no count");
        else check("ones_last roundtrip", acc0, c0.pop_front());
        nb0 = 0; acc0 = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_en) bit_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input int c);
    bit got;
    got = 1'b0;
    cnt_in = CW'(c);
    cnt_valid = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = if1.cnt_ready;
      step();
    end
    if (got) model_push(c);
    else fail_now("push timeout");
    cnt_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = !if1.busy && !if0.busy && !if1.bit_valid && !if0.bit_valid &&
             q1.size() == 0 && q0.size() == 0;
      if (!done) step();
    end
    if (!done) fail_now("drain timeout");
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " bit_valid"}, if1.bit_valid, 0);
    check({tag, " busy"}, if1.busy, 0);
    check({tag, " sat_err"}, if1.sat_err, 0);
    check({tag, " cnt_ready"}, if1.cnt_ready, 1);
    check({tag, " bit_out"}, if1.bit_out, 0);
    check({tag, " sof"}, if1.sof, 0);
    check({tag, " ones_last bit_valid"}, if0.bit_valid, 0);
    check({tag, " ones_last cnt_ready"}, if0.cnt_ready, 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();

    // Single group: first bit two cycles after the push cycle, busy drops the cycle after the last bit.
    push(3);
    @(negedge clk); check("lat N+1 bit_valid", if1.bit_valid, 0); check("lat N+1 busy", if1.busy, 1);
    @(negedge clk); check("lat N+2 bit_valid", if1.bit_valid, 1); check("lat N+2 sof", if1.sof, 1);
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      check("lat bit_valid", if1.bit_valid, 1);
      check("lat sof", if1.sof, 0);
    end
    check("lat N+5 busy", if1.busy, 1);
    @(negedge clk); check("lat N+6 busy", if1.busy, 0); check("lat N+6 bit_valid", if1.bit_valid, 0);
    step();
    drain();

    push(0);
    push(4);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b bit_valid", if1.bit_valid, 1);
      check("b2b sof", if1.sof, (i % 4 == 0) ? 1 : 0);
    end
    step();
    drain();

    push(9);
    @(negedge clk); check("sat_err pulse", if1.sat_err, 1);
    @(negedge clk); check("sat_err clears", if1.sat_err, 0);
    step();
    drain();

    push(1);
    drain();

    // Stall on bit 1 of a count-2 group while the FIFO fills.
    push(2);
    @(negedge clk);
    @(negedge clk); check("bp first bit_valid", if1.bit_valid, 1);
    step();
    bit_ready = 1'b0;
    push(3);
    push(1);
    cnt_in = CW'(4);
    cnt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp cnt_ready full", if1.cnt_ready, 0);
      check("bp bit_valid held", if1.bit_valid, 1);
      check("bp ones_first bit_out held", if1.bit_out, 1);
      check("bp ones_last bit_out held", if0.bit_out, 0);
      check("bp sof held", if1.sof, 0);
      step();
    end
    bit_ready = 1'b1;
    push(4);
    drain();

    // Reset at pos 2 with another group queued: nothing may come out afterwards.
    push(4);
    push(3);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post reset bit_valid", if1.bit_valid | if0.bit_valid, 0);
      check("post reset busy", if1.busy | if0.busy, 0);
    end
    step();

    rnd_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) step();
      push($urandom_range(0, 5));
    end
    drain();
    rnd_en = 1'b0;
    bit_ready = 1'b1;
    step();

    check("final ones_first queue empty", q1.size(), 0);
    check("final ones_last queue empty", q0.size(), 0);
    check("final roundtrip counts empty", c1.size() + c0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
